// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the MIPS fetch stage.
package instruction_fetch_pkg;

    localparam logic [31:0] NOP_WORD    = 32'h0000_0000;
    localparam int unsigned INSTR_BYTES = 32'd4;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    // A fetch address is unusable if it is not word aligned or lies past the last word.
    function automatic logic addr_fault(input logic [31:0] addr, input logic [31:0] last_addr);
        return (addr[1:0] != 2'b00) || (addr > last_addr);
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: control from hazard/decode, instruction memory port and IF/ID outputs.
interface instruction_fetch_if;

    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    modport master (
        input  stall, redirect, redirect_pc, imem_data,
        output imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid, halted, fetch_count
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_data,
        input  imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid, halted, fetch_count
    );

endinterface

// File: rtl/instruction_fetch_if_id_register.sv
// IF/ID pipeline register: load a fetched word, squash a wrong-path word, or drop validity.
module instruction_fetch_if_id_register
    import instruction_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        squash,
    input  logic        invalidate,
    input  logic [31:0] fetch_instr,
    input  logic [31:0] fetch_pc4,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    logic [31:0] instr_r;
    logic [31:0] pc4_r;
    logic        valid_r;

    // Register update; squash wins over invalidate, which wins over load, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_r <= NOP_WORD;
            pc4_r   <= 32'h0000_0000;
            valid_r <= 1'b0;
        end else if (squash) begin
            instr_r <= NOP_WORD;
            valid_r <= 1'b0;
        end else if (invalidate) begin
            valid_r <= 1'b0;
        end else if (load) begin
            instr_r <= fetch_instr;
            pc4_r   <= fetch_pc4;
            valid_r <= 1'b1;
        end else begin
            instr_r <= instr_r;
            pc4_r   <= pc4_r;
            valid_r <= valid_r;
        end
    end

    assign instr = instr_r;
    assign pc4   = pc4_r;
    assign valid = valid_r;

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: program counter, next-PC selection, fault halt and IF/ID capture.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 32'd32
) (
    input  logic               clk,
    input  logic               rst,
    instruction_fetch_if.master bus
);

    localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - INSTR_BYTES);

    fetch_state_e state_r;
    fetch_state_e state_nxt_s;
    logic [31:0]  pc_r;
    logic [31:0]  pc_nxt_s;
    logic [31:0]  pc_plus4_s;
    logic [31:0]  count_r;
    logic [31:0]  count_nxt_s;
    logic         halted_r;
    logic         load_s;
    logic         squash_s;
    logic         invalidate_s;
    logic [31:0]  if_id_instr_s;
    logic [31:0]  if_id_pc4_s;
    logic         if_id_valid_s;

    assign pc_plus4_s = pc_r + 32'(INSTR_BYTES);

    // Next-state and IF/ID control; redirect beats stall, a halted stage ignores both.
    always_comb begin
        state_nxt_s  = state_r;
        pc_nxt_s     = pc_r;
        count_nxt_s  = count_r;
        load_s       = 1'b0;
        squash_s     = 1'b0;
        invalidate_s = 1'b0;
        case (state_r)
            RUN: begin
                if (bus.redirect) begin
                    squash_s = 1'b1;
                    if (addr_fault(bus.redirect_pc, LAST_ADDR)) begin
                        state_nxt_s = HALTED;
                    end else begin
                        pc_nxt_s = bus.redirect_pc;
                    end
                end else if (bus.stall) begin
                    pc_nxt_s = pc_r;
                end else if (addr_fault(pc_r, LAST_ADDR)) begin
                    // Range check here keeps pc from ever wrapping around.
                    invalidate_s = 1'b1;
                    state_nxt_s  = HALTED;
                end else begin
                    load_s      = 1'b1;
                    pc_nxt_s    = pc_plus4_s;
                    count_nxt_s = count_r + 32'd1;
                end
            end
            HALTED: begin
                invalidate_s = 1'b1;
            end
            default: begin
                invalidate_s = 1'b1;
                state_nxt_s  = HALTED;
            end
        endcase
    end

    // PC, fetch counter, FSM state and sticky halt flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= RUN;
            pc_r     <= RESET_PC;
            count_r  <= 32'h0000_0000;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            pc_r     <= pc_nxt_s;
            count_r  <= count_nxt_s;
            halted_r <= (state_nxt_s == HALTED);
        end
    end

    instruction_fetch_if_id_register u_if_id (
        .clk         (clk),
        .rst         (rst),
        .load        (load_s),
        .squash      (squash_s),
        .invalidate  (invalidate_s),
        .fetch_instr (bus.imem_data),
        .fetch_pc4   (pc_plus4_s),
        .instr       (if_id_instr_s),
        .pc4         (if_id_pc4_s),
        .valid       (if_id_valid_s)
    );

    assign bus.imem_addr   = pc_r;
    assign bus.pc          = pc_r;
    assign bus.halted      = halted_r;
    assign bus.fetch_count = count_r;
    assign bus.if_id_instr = if_id_instr_s;
    assign bus.if_id_pc4   = if_id_pc4_s;
    assign bus.if_id_valid = if_id_valid_s;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a reference model feeding an expected-value queue.
module tb_instruction_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    instruction_fetch_if bus ();

    instruction_fetch #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    logic [31:0] mem [0:7];

    assign bus.imem_data = (bus.imem_addr < 32'd32) ? mem[bus.imem_addr[4:2]] : 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] count;
        logic        valid;
        logic        halted;
    } exp_t;

    exp_t exp_q[$];

    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid, m_halted;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference behaviour of one rising edge with the inputs currently applied.
    task automatic model(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        if (r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
            m_valid = 1'b0; m_halted = 1'b0; m_count = 32'h0;
        end else if (m_halted) begin
            m_valid = 1'b0;
        end else if (rd) begin
            m_valid = 1'b0;
            m_instr = 32'h0;
            if (rpc[1:0] != 2'b00 || rpc > 32'd28) m_halted = 1'b1;
            else m_pc = rpc;
        end else if (s) begin
            m_pc = m_pc;
        end else if (m_pc > 32'd28) begin
            m_halted = 1'b1;
            m_valid  = 1'b0;
        end else begin
            m_instr = mem[m_pc[4:2]];
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_count = m_count + 32'd1;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        exp_t e;
        rst             = r;
        bus.stall       = s;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        model(r, s, rd, rpc);
        e = '{pc: m_pc, instr: m_instr, pc4: m_pc4, count: m_count, valid: m_valid, halted: m_halted};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check32("pc", bus.pc, e.pc);
        check32("imem_addr", bus.imem_addr, e.pc);
        check32("if_id_instr", bus.if_id_instr, e.instr);
        check32("if_id_pc4", bus.if_id_pc4, e.pc4);
        check32("if_id_valid", {31'd0, bus.if_id_valid}, {31'd0, e.valid});
        check32("halted", {31'd0, bus.halted}, {31'd0, e.halted});
        check32("fetch_count", bus.fetch_count, e.count);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 32'h1111_1111 * (i + 1);
        bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;

        // Reset, then two fetches to reach pc=8.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check32("reset_pc", bus.pc, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check32("seq1_instr", bus.if_id_instr, 32'h1111_1111);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check32("seq2_instr", bus.if_id_instr, 32'h2222_2222);
        check32("seq2_pc", bus.pc, 32'd8);

        // Stall for three cycles at pc=8, then the word at 8 lands.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        check32("stall_pc", bus.pc, 32'd8);
        check32("stall_count", bus.fetch_count, 32'd2);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check32("seq3_instr", bus.if_id_instr, 32'h3333_3333);
        check32("seq3_pc4", bus.if_id_pc4, 32'd12);
        check32("seq3_count", bus.fetch_count, 32'd3);

        // Redirect to 4 with stall asserted: one bubble, then the target word.
        step(1'b0, 1'b1, 1'b1, 32'd4);
        check32("redir_pc", bus.pc, 32'd4);
        check32("redir_valid", {31'd0, bus.if_id_valid}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check32("redir_instr", bus.if_id_instr, 32'h2222_2222);
        check32("redir_pc4", bus.if_id_pc4, 32'd8);

        // Misaligned redirect halts; further redirects and stalls are ignored.
        step(1'b0, 1'b0, 1'b1, 32'd6);
        check32("misalign_halted", {31'd0, bus.halted}, 32'd1);
        check32("misalign_pc", bus.pc, 32'd8);
        step(1'b0, 1'b0, 1'b1, 32'd0);
        step(1'b0, 1'b1, 1'b1, 32'd12);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check32("halt_sticky", {31'd0, bus.halted}, 32'd1);

        // Run off the end of a 32-byte memory.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        check32("end_last_instr", bus.if_id_instr, 32'h8888_8888);
        check32("end_count", bus.fetch_count, 32'd8);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check32("end_pc", bus.pc, 32'd32);
        check32("end_halted", {31'd0, bus.halted}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0);

        // Out-of-range redirect target.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'd32);
        check32("range_halted", {31'd0, bus.halted}, 32'd1);

        // Reset pulse while IF/ID is valid, then restart from RESET_PC.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check32("midrst_valid", {31'd0, bus.if_id_valid}, 32'd0);
        check32("midrst_pc", bus.pc, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check32("restart_instr", bus.if_id_instr, 32'h1111_1111);
        check32("restart_pc4", bus.if_id_pc4, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
